// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encodings (common with the master so debug
// buses line up), transfer direction and line-level ACK constants.
package i2c_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ADDR      = 3'd1;
   localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
   localparam logic [2:0] ST_RX_DATA   = 3'd3;
   localparam logic [2:0] ST_RX_ACK    = 3'd4;
   localparam logic [2:0] ST_TX_DATA   = 3'd5;
   localparam logic [2:0] ST_TX_ACK    = 3'd6;
   localparam logic [2:0] ST_WAIT_STOP = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_ADDR      = ST_ADDR,
      S_ADDR_ACK  = ST_ADDR_ACK,
      S_RX_DATA   = ST_RX_DATA,
      S_RX_ACK    = ST_RX_ACK,
      S_TX_DATA   = ST_TX_DATA,
      S_TX_ACK    = ST_TX_ACK,
      S_WAIT_STOP = ST_WAIT_STOP
   } state_e;

   localparam logic I2C_READ  = 1'b1;
   localparam logic I2C_WRITE = 1'b0;
   localparam logic ACK       = 1'b0;
   localparam logic NACK      = 1'b1;

endpackage

// File: rtl/i2c_slave_target_if.sv
// Bus pins and byte-level application handshake of the I2C target.
interface i2c_slave_target_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_out;
   logic [7:0] s_data_i;
   logic [7:0] s_data_o;
   logic       s_data_valid_o;
   logic       s_data_req_o;
   logic       s_busy_o;
   logic       s_stop_o;
   logic       s_error_o;

   modport slave (
      input  scl_in, sda_in, s_data_i,
      output sda_out, s_data_o, s_data_valid_o, s_data_req_o,
             s_busy_o, s_stop_o, s_error_o
   );

   modport master (
      output scl_in, sda_in, s_data_i,
      input  sda_out, s_data_o, s_data_valid_o, s_data_req_o,
             s_busy_o, s_stop_o, s_error_o
   );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with a history flop; derives SCL edges and START/STOP.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_s_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_hist_q;
   logic                   sda_hist_q;
   logic                   scl_s;
   logic                   sda_s;

   // Idle bus level is high, so reset preloads ones to avoid phantom edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_hist_q <= scl_s;
         sda_hist_q <= sda_s;
      end
   end

   assign scl_s      = scl_sync_q[SYNC_STAGES-1];
   assign sda_s      = sda_sync_q[SYNC_STAGES-1];
   assign sda_s_o    = sda_s;
   assign scl_rise_o = scl_s & ~scl_hist_q;
   assign scl_fall_o = ~scl_s & scl_hist_q;
   assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
   assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target: address match, write-byte reception and read-byte transmission
// driven from an oversampled SCL/SDA, with a byte-level application handshake.
import i2c_pkg::*;

module i2c_slave_target #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input logic              clk,
   input logic              rst,
   i2c_slave_target_if.slave bus
);

   logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (bus.scl_in),
      .sda_i      (bus.sda_in),
      .sda_s_o    (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_ev),
      .stop_o     (stop_ev)
   );

   state_e     state_q, state_d;
   logic [3:0] bitcnt_q, bitcnt_d;
   logic [6:0] shift_q, shift_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] data_q, data_d;
   logic [7:0] rx_byte;
   logic       rw_q, rw_d;
   logic       phase_q, phase_d;
   logic       sda_out_q, sda_out_d;
   logic       busy_q, busy_d;
   logic       valid_q, valid_d;
   logic       req_q, req_d;
   logic       stop_q, stop_d;
   logic       err_q, err_d;

   assign rx_byte = {shift_q, sda_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         tx_q      <= '0;
         data_q    <= '0;
         rw_q      <= 1'b0;
         phase_q   <= 1'b0;
         sda_out_q <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         req_q     <= 1'b0;
         stop_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         data_q    <= data_d;
         rw_q      <= rw_d;
         phase_q   <= phase_d;
         sda_out_q <= sda_out_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         req_q     <= req_d;
         stop_q    <= stop_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      data_d    = data_q;
      rw_d      = rw_q;
      phase_d   = phase_q;
      sda_out_d = sda_out_q;
      busy_d    = busy_q;
      valid_d   = 1'b0;
      req_d     = 1'b0;
      stop_d    = 1'b0;
      err_d     = 1'b0;

      // Read data is captured in the cycle the request pulse is visible.
      if (req_q) tx_d = bus.s_data_i;

      if (stop_ev) begin
         state_d   = S_IDLE;
         sda_out_d = 1'b0;
         busy_d    = 1'b0;
         stop_d    = busy_q;
         bitcnt_d  = '0;
         phase_d   = 1'b0;
      end else if (start_ev) begin
         state_d   = S_ADDR;
         sda_out_d = 1'b0;
         bitcnt_d  = '0;
         phase_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: if (scl_rise) begin
               shift_d = rx_byte[6:0];
               if (bitcnt_q == 4'd7) begin
                  bitcnt_d = '0;
                  rw_d     = sda_s;
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                     state_d = S_ADDR_ACK;
                     busy_d  = 1'b1;
                     req_d   = (sda_s == I2C_READ);
                  end else begin
                     state_d = S_WAIT_STOP;
                     busy_d  = 1'b0;
                  end
               end else begin
                  bitcnt_d = bitcnt_q + 4'd1;
               end
            end
            // phase_q separates the fall that starts the ACK from the one ending it.
            S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
               if (!phase_q) begin
                  phase_d   = 1'b1;
                  sda_out_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (state_q == S_ADDR_ACK && rw_q == I2C_READ) begin
                     state_d   = S_TX_DATA;
                     sda_out_d = ~tx_q[7];
                  end else begin
                     state_d   = S_RX_DATA;
                     sda_out_d = 1'b0;
                  end
               end
            end
            S_RX_DATA: if (scl_rise) begin
               shift_d = rx_byte[6:0];
               if (bitcnt_q == 4'd7) begin
                  bitcnt_d = '0;
                  data_d   = rx_byte;
                  valid_d  = 1'b1;
                  state_d  = S_RX_ACK;
               end else begin
                  bitcnt_d = bitcnt_q + 4'd1;
               end
            end
            S_TX_DATA: if (scl_rise) begin
               // Released for a 1 yet the line reads low: someone else owns SDA.
               if (!sda_out_q && sda_s != NACK) begin
                  err_d     = 1'b1;
                  state_d   = S_WAIT_STOP;
                  sda_out_d = 1'b0;
                  bitcnt_d  = '0;
               end
            end else if (scl_fall) begin
               if (bitcnt_q == 4'd7) begin
                  bitcnt_d  = '0;
                  sda_out_d = 1'b0;
                  state_d   = S_TX_ACK;
               end else begin
                  bitcnt_d  = bitcnt_q + 4'd1;
                  sda_out_d = ~tx_q[3'd6 - bitcnt_q[2:0]];
               end
            end
            S_TX_ACK: if (scl_rise && !phase_q) begin
               if (sda_s == ACK) begin
                  req_d   = 1'b1;
                  phase_d = 1'b1;
               end else begin
                  state_d = S_WAIT_STOP;
               end
            end else if (scl_fall && phase_q) begin
               phase_d   = 1'b0;
               state_d   = S_TX_DATA;
               sda_out_d = ~tx_q[7];
            end
            S_WAIT_STOP: sda_out_d = 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.sda_out        = sda_out_q;
   assign bus.s_data_o       = data_q;
   assign bus.s_data_valid_o = valid_q;
   assign bus.s_data_req_o   = req_q;
   assign bus.s_busy_o       = busy_q;
   assign bus.s_stop_o       = stop_q;
   assign bus.s_error_o      = err_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: a bit-banged master on an open-drain
// SDA model with pulse counters on the application-side outputs.
module tb_i2c_slave_target;

   localparam int Q = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       m_low = 1'b0;
   logic       force_low = 1'b0;
   logic [7:0] sdata_i = 8'h00;
   logic       sda_line;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int req_cnt = 0;
   int stop_cnt = 0;
   int err_cnt = 0;
   int sda_hi_cnt = 0;

   i2c_slave_target_if bus ();

   assign sda_line     = ~(m_low | bus.sda_out | force_low);
   assign bus.sda_in   = sda_line;
   assign bus.scl_in   = scl_m;
   assign bus.s_data_i = sdata_i;

   i2c_slave_target #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (bus.s_data_valid_o) valid_cnt++;
      if (bus.s_data_req_o)   req_cnt++;
      if (bus.s_stop_o)       stop_cnt++;
      if (bus.s_error_o)      err_cnt++;
      if (bus.sda_out)        sda_hi_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_low = 1'b0; wq();
      scl_m = 1'b1; wq(); wq();
      m_low = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; wq();
      scl_m = 1'b1; wq();
      m_low = 1'b0; wq(); wq();
   endtask

   task automatic write_bit(input logic b);
      m_low = ~b; wq();
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic read_bit(output logic b, input logic frc);
      m_low = 1'b0; force_low = frc; wq();
      scl_m = 1'b1; wq();
      b = sda_line; wq();
      scl_m = 1'b0; wq();
      force_low = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         read_bit(b, 1'b0);
         d = {d[6:0], b};
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.sda_out !== 1'b0) begin errors++; $display("FAIL reset_sda_out: got %b expected 0", bus.sda_out); end
      checks++; if (bus.s_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.s_data_o); end
      checks++; if (bus.s_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.s_busy_o); end
      checks++; if ({bus.s_data_valid_o, bus.s_data_req_o, bus.s_stop_o, bus.s_error_o} !== 4'b0000) begin
         errors++; $display("FAIL reset_pulses: got %b expected 0000",
                            {bus.s_data_valid_o, bus.s_data_req_o, bus.s_stop_o, bus.s_error_o});
      end
      rst = 1'b0;
      wq();
   endtask

   task automatic test_write();
      logic a;
      int v0, s0;
      v0 = valid_cnt; s0 = stop_cnt;
      i2c_start();
      write_byte(8'hA0);
      read_bit(a, 1'b0);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b expected 0", a); end
      checks++; if (bus.s_busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", bus.s_busy_o); end
      write_byte(8'hA5);
      read_bit(a, 1'b0);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_data_ack: got %b expected 0", a); end
      checks++; if (bus.s_data_o !== 8'hA5) begin errors++; $display("FAIL wr_data: got %h expected a5", bus.s_data_o); end
      checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL wr_valid_count: got %0d expected 1", valid_cnt - v0); end
      i2c_stop();
      checks++; if (stop_cnt - s0 !== 1) begin errors++; $display("FAIL wr_stop_count: got %0d expected 1", stop_cnt - s0); end
      checks++; if (bus.s_busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b expected 0", bus.s_busy_o); end
   endtask

   task automatic test_mismatch();
      logic a;
      int v0, r0, s0, h0;
      v0 = valid_cnt; r0 = req_cnt; s0 = stop_cnt; h0 = sda_hi_cnt;
      i2c_start();
      write_byte(8'hA2);
      read_bit(a, 1'b0);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL mm_nack: got %b expected 1", a); end
      checks++; if (bus.s_busy_o !== 1'b0) begin errors++; $display("FAIL mm_busy: got %b expected 0", bus.s_busy_o); end
      write_byte(8'h12);
      i2c_stop();
      checks++; if (sda_hi_cnt - h0 !== 0) begin errors++; $display("FAIL mm_sda_driven: got %0d cycles expected 0", sda_hi_cnt - h0); end
      checks++; if ((valid_cnt - v0) + (req_cnt - r0) !== 0) begin
         errors++; $display("FAIL mm_pulses: got %0d expected 0", (valid_cnt - v0) + (req_cnt - r0));
      end
      checks++; if (stop_cnt - s0 !== 0) begin errors++; $display("FAIL mm_stop: got %0d expected 0", stop_cnt - s0); end
   endtask

   task automatic test_read();
      logic a;
      logic [7:0] d;
      int r0, s0;
      r0 = req_cnt; s0 = stop_cnt;
      sdata_i = 8'h3C;
      i2c_start();
      write_byte(8'hA1);
      read_bit(a, 1'b0);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b expected 0", a); end
      checks++; if (req_cnt - r0 !== 1) begin errors++; $display("FAIL rd_req_first: got %0d expected 1", req_cnt - r0); end
      read_byte(d);
      checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rd_byte0: got %h expected 3c", d); end
      sdata_i = 8'hC3;
      write_bit(1'b0);
      read_byte(d);
      checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd_byte1: got %h expected c3", d); end
      write_bit(1'b1);
      wq();
      checks++; if (req_cnt - r0 !== 2) begin errors++; $display("FAIL rd_req_total: got %0d expected 2", req_cnt - r0); end
      checks++; if ({bus.sda_out, bus.s_busy_o} !== 2'b01) begin
         errors++; $display("FAIL rd_wait_stop: got sda_out/busy %b expected 01", {bus.sda_out, bus.s_busy_o});
      end
      i2c_stop();
      checks++; if (stop_cnt - s0 !== 1) begin errors++; $display("FAIL rd_stop: got %0d expected 1", stop_cnt - s0); end
   endtask

   task automatic test_restart();
      logic a;
      logic [7:0] d;
      int v0;
      v0 = valid_cnt;
      sdata_i = 8'h96;
      i2c_start();
      write_byte(8'hA0);
      read_bit(a, 1'b0);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
      i2c_start();
      write_byte(8'hA1);
      read_bit(a, 1'b0);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b expected 0", a); end
      read_byte(d);
      checks++; if (d !== 8'h96) begin errors++; $display("FAIL rs_read: got %h expected 96", d); end
      checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL rs_partial_valid: got %0d expected 0", valid_cnt - v0); end
      write_bit(1'b1);
      checks++; if (bus.s_busy_o !== 1'b1) begin errors++; $display("FAIL rs_busy: got %b expected 1", bus.s_busy_o); end
      i2c_stop();
   endtask

   task automatic test_reset_mid_ack();
      logic a;
      int n;
      i2c_start();
      write_byte(8'hA0);
      n = 0;
      while (bus.sda_out !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++; if (bus.sda_out !== 1'b1) begin errors++; $display("FAIL ra_ack_driven: got %b expected 1", bus.sda_out); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({bus.sda_out, bus.s_busy_o} !== 2'b00) begin
         errors++; $display("FAIL ra_after_rst: got sda_out/busy %b expected 00", {bus.sda_out, bus.s_busy_o});
      end
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
      i2c_stop();
      i2c_start();
      write_byte(8'hA0);
      read_bit(a, 1'b0);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL ra_readdr_ack: got %b expected 0", a); end
      write_byte(8'h5A);
      read_bit(a, 1'b0);
      checks++; if (bus.s_data_o !== 8'h5A) begin errors++; $display("FAIL ra_data: got %h expected 5a", bus.s_data_o); end
      i2c_stop();
   endtask

   task automatic test_error();
      logic a, b;
      int e0, h0;
      e0 = err_cnt; h0 = 0;
      sdata_i = 8'h3C;
      i2c_start();
      write_byte(8'hA1);
      read_bit(a, 1'b0);
      for (int i = 0; i < 8; i++) begin
         read_bit(b, i == 2);
         if (i == 2) begin
            h0 = sda_hi_cnt;
            checks++; if (bus.sda_out !== 1'b0) begin errors++; $display("FAIL er_released: got %b expected 0", bus.sda_out); end
         end
      end
      checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL er_count: got %0d expected 1", err_cnt - e0); end
      checks++; if (sda_hi_cnt - h0 !== 0) begin errors++; $display("FAIL er_sda_after: got %0d cycles expected 0", sda_hi_cnt - h0); end
      write_bit(1'b1);
      i2c_stop();
   endtask

   initial begin
      test_reset();
      test_write();
      test_mismatch();
      test_read();
      test_restart();
      test_reset_mid_ack();
      test_error();
      test_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
